mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, data/address width.
REQ-002 SHALL have parameter NB_REG, default 5, register-index width.
REQ-003 SHALL have parameter NB_ADDR, default 6, data-memory word-address bits (2^NB_ADDR words).
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port i_reset  input  1  reset: asynchronous, active-low.
REQ-006 SHALL have port i_step  input  1  stall; stage advances only while low.
REQ-007 SHALL have port i_mem2reg  input  1  writeback selects load data.
REQ-008 SHALL have port i_memWrite  input  1  store request.
REQ-009 SHALL have port i_regWrite  input  1  writeback enable.
REQ-010 SHALL have port i_width  input  2  access size: 00 byte, 01 halfword, 10 and 11 word.
REQ-011 SHALL have port i_sign_flag  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-012 SHALL have port i_result  input  NB_DATA  ALU result; byte address for memory ops.
REQ-013 SHALL have port i_data4Mem  input  NB_DATA  store data.
REQ-014 SHALL have port i_write_reg  input  NB_REG  destination register.
REQ-015 SHALL have port i_dbg_addr  input  NB_ADDR  debug word address.
REQ-016 SHALL have port o_read_data  output  NB_DATA  extended load data (MEM/WB).
REQ-017 SHALL have port o_result  output  NB_DATA  forwarded ALU result (MEM/WB).
REQ-018 SHALL have ports o_mem2reg, o_regWrite  output  1 each  forwarded controls (MEM/WB).
REQ-019 SHALL have port o_write_reg  output  NB_REG  forwarded destination (MEM/WB).
REQ-020 SHALL have port o_misaligned  output  1  sticky misaligned-access flag.
REQ-021 SHALL have port o_dbg_data  output  NB_DATA  registered debug memory word.

Function
REQ-022 Memory SHALL be 2^NB_ADDR x NB_DATA words, indexed by i_result[NB_ADDR+1:2]; higher address bits ignored (wrap).
REQ-023 Byte order SHALL be little-endian: byte lane n = bits 8n+7:8n, lane = i_result[1:0]; halfword lane = i_result[1].
REQ-024 Access SHALL be misaligned when halfword with i_result[0]=1, or word with i_result[1:0]!=00; byte never misaligned.
REQ-025 Store: when i_step=0, i_memWrite=1, aligned -> on clock edge write only selected lane(s) with low byte/half/word of i_data4Mem; other lanes unchanged.
REQ-026 Misaligned store SHALL not modify memory.
REQ-027 Load path: selected byte/half extended per i_sign_flag to NB_DATA, word unchanged; registered into o_read_data when i_step=0 (1-cycle latency).
REQ-028 o_read_data SHALL be captured every advancing cycle regardless of i_mem2reg; misaligned access with i_mem2reg=1 SHALL capture 0.
REQ-029 When i_step=0, o_result, o_mem2reg, o_write_reg SHALL take i_result, i_mem2reg, i_write_reg next edge.
REQ-030 When i_step=0, o_regWrite SHALL take i_regWrite, forced 0 if i_mem2reg=1 and access misaligned.
REQ-031 o_misaligned SHALL set on an advancing edge where (i_memWrite or i_mem2reg) and misaligned; stays set until reset.
REQ-032 When i_step=1, all MEM/WB outputs and o_misaligned SHALL hold, and no store SHALL occur.
REQ-033 i_memWrite=1 with i_mem2reg=1 SHALL perform the store and capture pre-store (old) memory data in o_read_data.
REQ-034 o_dbg_data SHALL register mem[i_dbg_addr] every edge independent of i_step, showing contents before a same-edge store.

Reset
REQ-035 On i_reset=0, immediately: o_read_data, o_result, o_write_reg, o_dbg_data = 0; o_mem2reg, o_regWrite, o_misaligned = 0.
REQ-036 Memory contents SHALL not be affected by reset; a store coinciding with reset assertion SHALL not occur.
REQ-037 After reset release, first advancing edge SHALL behave per REQ-025..031 with no residual state.

Verification
REQ-038 Word store 0xDEADBEEF at addr 0x08, then word load addr 0x08 -> o_read_data=0xDEADBEEF one cycle later, o_regWrite=1.
REQ-039 Byte store 0x7F5A at addr 0x09 over 0xDEADBEEF -> word at 0x08 = 0xDEAD5AEF; signed byte load 0x0B -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-040 Halfword load addr 0x0A signed over 0x8001BEEF -> 0xFFFF8001; addr 0x0B -> o_read_data=0, o_regWrite=0, o_misaligned=1 and stays 1.
REQ-041 Misaligned word store at 0x0E of 0x11111111 -> word at 0x0C unchanged (check via i_dbg_addr=3), o_misaligned=1.
REQ-042 i_step=1 for 3 cycles with store pending -> outputs hold, memory unchanged; i_step=0 -> store occurs one edge later.
REQ-043 Assert i_reset mid-stream between edges -> all outputs 0 immediately, memory retains prior data (debug read of 0x08 word intact).

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: little-endian byte/half/word data memory with the MEM/WB register,
// a sticky misaligned-access flag and a registered debug read port.
module mem_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_ADDR = 6
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int unsigned N_WORDS = 1 << NB_ADDR;

    logic [NB_DATA-1:0] r_mem [N_WORDS];

    logic [NB_DATA-1:0] r_read_data;
    logic [NB_DATA-1:0] r_result;
    logic               r_mem2reg;
    logic               r_regWrite;
    logic [NB_REG-1:0]  r_write_reg;
    logic               r_misaligned;
    logic [NB_DATA-1:0] r_dbg_data;

    logic [NB_ADDR-1:0] w_idx;
    logic [NB_DATA-1:0] w_word;
    logic [4:0]         w_bshift;
    logic [4:0]         w_hshift;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_misaligned;
    logic [NB_DATA-1:0] w_load;
    logic [NB_DATA-1:0] w_wmask;
    logic [NB_DATA-1:0] w_wdata;
    logic               w_store;

    assign w_idx    = i_result[NB_ADDR+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_bshift = {i_result[1:0], 3'b000};
    assign w_hshift = {i_result[1], 4'b0000};
    assign w_byte   = w_word[w_bshift +: 8];
    assign w_half   = w_word[w_hshift +: 16];
    assign w_store  = !i_step && i_memWrite && !w_misaligned;

    // Alignment check and lane extraction/extension for loads
    always_comb begin
        w_misaligned = 1'b0;
        w_load       = w_word;
        case (i_width)
            2'b00: begin
                w_load = i_sign_flag ? {{(NB_DATA-8){w_byte[7]}}, w_byte}
                                     : {{(NB_DATA-8){1'b0}}, w_byte};
            end
            2'b01: begin
                w_misaligned = i_result[0];
                w_load = i_sign_flag ? {{(NB_DATA-16){w_half[15]}}, w_half}
                                     : {{(NB_DATA-16){1'b0}}, w_half};
            end
            default: begin
                w_misaligned = (i_result[1:0] != 2'b00);
            end
        endcase
    end

    // Lane mask and lane-aligned store data
    always_comb begin
        w_wmask = '1;
        w_wdata = i_data4Mem;
        case (i_width)
            2'b00: begin
                w_wmask = NB_DATA'(8'hFF) << w_bshift;
                w_wdata = NB_DATA'(i_data4Mem[7:0]) << w_bshift;
            end
            2'b01: begin
                w_wmask = NB_DATA'(16'hFFFF) << w_hshift;
                w_wdata = NB_DATA'(i_data4Mem[15:0]) << w_hshift;
            end
            default: begin
                w_wmask = '1;
                w_wdata = i_data4Mem;
            end
        endcase
    end

    // Memory contents survive reset; an edge while reset is held never stores
    always_ff @(posedge clk or negedge i_reset) begin
        if (i_reset && w_store) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    // MEM/WB register, sticky flag and debug port
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_read_data  <= '0;
            r_result     <= '0;
            r_mem2reg    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_write_reg  <= '0;
            r_misaligned <= 1'b0;
            r_dbg_data   <= '0;
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
            if (!i_step) begin
                r_read_data  <= (w_misaligned && i_mem2reg) ? '0 : w_load;
                r_result     <= i_result;
                r_mem2reg    <= i_mem2reg;
                r_regWrite   <= i_regWrite && !(i_mem2reg && w_misaligned);
                r_write_reg  <= i_write_reg;
                r_misaligned <= r_misaligned || ((i_memWrite || i_mem2reg) && w_misaligned);
            end
        end
    end

    assign o_read_data  = r_read_data;
    assign o_result     = r_result;
    assign o_mem2reg    = r_mem2reg;
    assign o_regWrite   = r_regWrite;
    assign o_write_reg  = r_write_reg;
    assign o_misaligned = r_misaligned;
    assign o_dbg_data   = r_dbg_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_mem_stage;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_REG  = 5;
    localparam int unsigned NB_ADDR = 6;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_step;
    logic               i_mem2reg;
    logic               i_memWrite;
    logic               i_regWrite;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] i_data4Mem;
    logic [NB_REG-1:0]  i_write_reg;
    logic [NB_ADDR-1:0] i_dbg_addr;
    logic [NB_DATA-1:0] o_read_data;
    logic [NB_DATA-1:0] o_result;
    logic               o_mem2reg;
    logic               o_regWrite;
    logic [NB_REG-1:0]  o_write_reg;
    logic               o_misaligned;
    logic [NB_DATA-1:0] o_dbg_data;

    always #5 clk = ~clk;

    mem_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
        .clk(clk), .i_reset(i_reset), .i_step(i_step), .i_mem2reg(i_mem2reg),
        .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .i_width(i_width),
        .i_sign_flag(i_sign_flag), .i_result(i_result), .i_data4Mem(i_data4Mem),
        .i_write_reg(i_write_reg), .i_dbg_addr(i_dbg_addr), .o_read_data(o_read_data),
        .o_result(o_result), .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite),
        .o_write_reg(o_write_reg), .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: memory as a flat byte array plus expected outputs
    logic [7:0]  mem_b [256];
    logic [31:0] e_rd, e_res, e_dbg;
    logic        e_m2r, e_rw, e_mis, rd_valid;
    logic [4:0]  e_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word(input int a);
        return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
    endfunction

    function automatic logic [31:0] m_load(input int a, input logic [1:0] w, input logic sgn);
        logic [31:0] v;
        if (w == 2'b00) begin
            v = 32'(mem_b[a]);
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (w == 2'b01) begin
            v = 32'(mem_b[a & 8'hFE]) + 32'(mem_b[(a & 8'hFE) + 1]) * 32'd256;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = m_word(a & 8'hFC);
        end
        return v;
    endfunction

    task automatic check_all();
        if (!chk_en) return;
        if (rd_valid) chk("read_data", o_read_data, e_rd);
        chk("result",    o_result, e_res);
        chk("mem2reg",   32'(o_mem2reg), 32'(e_m2r));
        chk("regWrite",  32'(o_regWrite), 32'(e_rw));
        chk("write_reg", 32'(o_write_reg), 32'(e_wr));
        chk("misaligned", 32'(o_misaligned), 32'(e_mis));
        chk("dbg_data",  o_dbg_data, e_dbg);
    endtask

    task automatic model_reset();
        e_rd = '0; e_res = '0; e_dbg = '0; e_m2r = 1'b0; e_rw = 1'b0;
        e_mis = 1'b0; e_wr = '0; rd_valid = 1'b1;
    endtask

    // Apply one set of inputs across one rising edge, then compare against the model
    task automatic cycle(input logic step, input logic m2r, input logic mw, input logic rw,
                         input logic [1:0] w, input logic sgn, input logic [31:0] res,
                         input logic [31:0] data, input logic [4:0] wr, input logic [5:0] dbg);
        int  a;
        bit  mis;
        logic [31:0] d;
        i_step = step; i_mem2reg = m2r; i_memWrite = mw; i_regWrite = rw; i_width = w;
        i_sign_flag = sgn; i_result = res; i_data4Mem = data; i_write_reg = wr; i_dbg_addr = dbg;
        a   = int'(res[7:0]);
        mis = (w == 2'b01 && (a % 2) != 0) || (w[1] && (a % 4) != 0);
        d   = m_word(int'(dbg) * 4);
        if (!step) begin
            if (mis && m2r) begin
                e_rd = '0; rd_valid = 1'b1;
            end else if (mis) begin
                rd_valid = 1'b0;
            end else begin
                e_rd = m_load(a, w, sgn); rd_valid = 1'b1;
            end
            e_res = res; e_m2r = m2r; e_wr = wr;
            e_rw  = rw && !(m2r && mis);
            if ((mw || m2r) && mis) e_mis = 1'b1;
            if (mw && !mis) begin
                mem_b[a] = data[7:0];
                if (w != 2'b00) mem_b[a+1] = data[15:8];
                if (w[1]) begin
                    mem_b[a+2] = data[23:16];
                    mem_b[a+3] = data[31:24];
                end
            end
        end
        e_dbg = d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges, check outputs clear immediately, release before next edge
    task automatic reset_mid();
        #3 i_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_read_data", o_read_data, 32'h0);
        chk("rst_regWrite", 32'(o_regWrite), 32'h0);
        chk("rst_dbg", o_dbg_data, 32'h0);
        check_all();
        #2 i_reset = 1'b1;
    endtask

    typedef struct {
        logic        m2r, mw, rw;
        logic [1:0]  w;
        logic        sgn;
        logic [31:0] res, data;
        logic [31:0] x_rd;
        logic        x_rw, x_mis;
        logic [31:0] x_dbg;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h09, 32'h7F5A,     32'h000000BE, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEAD5AEF, 1'b1, 1'b0, 32'hDEAD5AEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0B, 32'h0,        32'hFFFFFFDE, 1'b1, 1'b0, 32'hDEAD5AEF};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0B, 32'h0,        32'h000000DE, 1'b1, 1'b0, 32'hDEAD5AEF};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h108,32'h8001BEEF, 32'hDEAD5AEF, 1'b0, 1'b0, 32'hDEAD5AEF};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0A, 32'h0,        32'hFFFF8001, 1'b1, 1'b0, 32'h8001BEEF};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h08, 32'h0,        32'h0000BEEF, 1'b1, 1'b0, 32'h8001BEEF};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0B, 32'h0,        32'h0,        1'b0, 1'b1, 32'h8001BEEF};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0,        32'h8001BEEF, 1'b1, 1'b1, 32'h8001BEEF};

        for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
        model_reset();
        i_reset = 1'b0; i_step = 1'b0; i_mem2reg = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
        i_width = 2'b00; i_sign_flag = 1'b0; i_result = '0; i_data4Mem = '0;
        i_write_reg = '0; i_dbg_addr = '0;

        // Reset state, then release between edges
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_all();
        #3 i_reset = 1'b1;

        // Clear the memory so every later expectation is defined
        chk_en = 1'b0;
        for (int i = 0; i < 64; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 5'd0, 6'd0);
        chk_en = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, tbl[i].m2r, tbl[i].mw, tbl[i].rw, tbl[i].w, tbl[i].sgn,
                  tbl[i].res, tbl[i].data, 5'(i + 1), 6'd2);
            chk($sformatf("tbl%0d_rd", i), o_read_data, tbl[i].x_rd);
            chk($sformatf("tbl%0d_rw", i), 32'(o_regWrite), 32'(tbl[i].x_rw));
            chk($sformatf("tbl%0d_mis", i), 32'(o_misaligned), 32'(tbl[i].x_mis));
            chk($sformatf("tbl%0d_dbg", i), o_dbg_data, tbl[i].x_dbg);
        end

        // Reset mid-stream: outputs clear at once, memory keeps its data
        reset_mid();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 6'd2);
        chk("post_rst_dbg", o_dbg_data, 32'h8001BEEF);
        chk("post_rst_mis", 32'(o_misaligned), 32'h0);

        // Misaligned word store leaves memory untouched and sets the flag
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0E, 32'h11111111, 5'd3, 6'd3);
        chk("mis_store_flag", 32'(o_misaligned), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 6'd3);
        chk("mis_store_mem", o_dbg_data, 32'h0);
        chk("mis_sticky", 32'(o_misaligned), 32'h1);

        // Stall with a pending store: nothing moves until i_step drops
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 5'd7, 6'd4);
            chk("stall_mem", o_dbg_data, 32'h0);
            chk("stall_result", o_result, 32'h0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 5'd7, 6'd4);
        chk("unstall_pre", o_dbg_data, 32'h0);
        chk("unstall_result", o_result, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 6'd4);
        chk("unstall_store", o_dbg_data, 32'h12345678);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_mid();
            cycle(($urandom % 4) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), $urandom, $urandom,
                  5'($urandom), 6'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
